// File: rtl/lc3_display_ctrl.sv
// ---------------------------------------------------------------------------
// lc3_display_ctrl
// Display output buffer for an LC-3 style CPU. CPU writes to the display data
// register are queued in a DEPTH-entry first-word-fall-through FIFO and handed
// to a ready/valid sink. A status word (dsr) reports ready/overflow/empty and
// the buffer occupancy.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   ddr_we     : CPU write strobe to the display data register
//   ddr_data   : word to display (DATA_W bits)
//   ovf_clr    : one-cycle clear of the sticky overflow flag
//   dsr        : display status {ready, overflow, empty, 5'b0, level[7:0]}
//   out_valid  : head-of-buffer word is available
//   out_data   : head-of-buffer word (oldest stored)
//   out_ready  : sink accepts out_data on this edge
//   level      : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module lc3_display_ctrl #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4,
    parameter int SIM_PRINT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ddr_we,
    input  logic [DATA_W-1:0]        ddr_data,
    input  logic                     ovf_clr,
    output logic [15:0]              dsr,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_EMPTY = LW'(0);

    // Storage is intentionally left unreset; only pointers and level qualify it.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;

    logic full_s;
    logic empty_s;
    logic pop_s;
    logic push_s;
    logic ovf_evt_s;
    logic [7:0] level8_s;

    assign full_s  = (level_q == LVL_FULL);
    assign empty_s = (level_q == LVL_EMPTY);
    assign pop_s   = out_ready && !empty_s;
    // A pop on the same edge frees a slot, so a write into a full buffer is
    // still accepted in that case.
    assign push_s    = ddr_we && (!full_s || pop_s);
    assign ovf_evt_s = ddr_we && full_s && !pop_s;

    // Next-state computation for pointers, occupancy and overflow flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // An overflow on the same edge as a clear keeps the flag set.
        if (ovf_evt_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Buffer storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= ddr_data;
        end
    end

    assign level8_s  = 8'(level_q);
    assign out_valid = !empty_s;
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign dsr       = {!full_s, ovf_q, empty_s, 5'b00000, level8_s};

`ifndef SYNTHESIS
    generate
        if (SIM_PRINT != 0) begin : g_print
            logic [15:0] print_word_s;
            assign print_word_s = 16'(out_data);

            // Simulation-only trace of each word accepted by the sink.
            always_ff @(posedge clk) begin
                if (!rst && pop_s) begin
                    $display("%0d", print_word_s);
                end
            end
        end
    endgenerate
`endif

endmodule
